// File: rtl/wb_sdram_bridge.sv
// Wishbone slave in front of sdr_controller: address window decode, posted write FIFO, strictly ordered reads, read timeout.
// Misses and write hits ack one cycle after accept; read ack follows ctrl_out_valid by one cycle; a full FIFO stalls writes with no ack.
module wb_sdram_bridge #(
    parameter int          ADDR_BITS   = 23,
    parameter int          WFIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
    parameter int          TIMEOUT     = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_dat_i,
    input  logic [31:0]                  wbs_adr_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    output logic [ADDR_BITS-1:0]         ctrl_addr,
    output logic                         ctrl_rw,
    output logic [31:0]                  ctrl_wdata,
    output logic [3:0]                   ctrl_mask,
    output logic                         ctrl_in_valid,
    input  logic                         ctrl_busy,
    input  logic [31:0]                  ctrl_rdata,
    input  logic                         ctrl_out_valid,
    output logic [$clog2(WFIFO_DEPTH):0] wfifo_level,
    output logic                         err_o,
    input  logic                         err_clr_i
);

    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [LW-1:0] LFULL = LW'(WFIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [31:0]          data;
        logic [3:0]           sel;
    } wentry_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISS,
        RD_ISS,
        RD_WAIT,
        RD_ACK
    } state_t;

    state_t        state;
    wentry_t       fifo_mem [WFIFO_DEPTH];
    wentry_t       head_ent;
    wentry_t       next_ent;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [TW-1:0] timer;

    logic req;
    logic hit;
    logic miss;
    logic wr_push;
    logic rd_take;
    logic pop;
    logic unused_adr_lsb;

    // Never accept during our own ack cycle, or a held strobe would be taken twice.
    assign req  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign hit  = (wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign miss = req & ~hit;

    // Fullness is judged on the pre-pop level, so a same-cycle pop does not free a slot.
    assign wr_push = req & hit & wbs_we_i & (wfifo_level < LFULL);
    assign rd_take = req & hit & ~wbs_we_i & (state == IDLE) & (wfifo_level == '0);
    assign pop     = (state == WR_ISS) & ~ctrl_busy;

    assign head_ent       = fifo_mem[rd_ptr];
    assign next_ent       = fifo_mem[rd_ptr + PW'(1)];
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wr_push) begin
            fifo_mem[wr_ptr] <= {wbs_adr_i[ADDR_BITS+1:2], wbs_dat_i, wbs_sel_i};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            ctrl_addr     <= '0;
            ctrl_rw       <= 1'b0;
            ctrl_wdata    <= '0;
            ctrl_mask     <= '0;
            ctrl_in_valid <= 1'b0;
            wfifo_level   <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            timer         <= '0;
            err_o         <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            if (miss || wr_push) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= '0;
            end

            if (wr_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wfifo_level <= wfifo_level + LW'(wr_push) - LW'(pop);

            if (err_clr_i) begin
                err_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Posted writes always drain ahead of any waiting read.
                    if (wfifo_level != '0) begin
                        state         <= WR_ISS;
                        ctrl_addr     <= head_ent.addr;
                        ctrl_wdata    <= head_ent.data;
                        ctrl_mask     <= head_ent.sel;
                        ctrl_rw       <= 1'b1;
                        ctrl_in_valid <= 1'b1;
                    end else if (rd_take) begin
                        state         <= RD_ISS;
                        ctrl_addr     <= wbs_adr_i[ADDR_BITS+1:2];
                        ctrl_mask     <= 4'b0000;
                        ctrl_rw       <= 1'b0;
                        ctrl_in_valid <= 1'b1;
                    end
                end
                WR_ISS: begin
                    if (!ctrl_busy) begin
                        if (wfifo_level > LW'(1)) begin
                            ctrl_addr  <= next_ent.addr;
                            ctrl_wdata <= next_ent.data;
                            ctrl_mask  <= next_ent.sel;
                        end else begin
                            state         <= IDLE;
                            ctrl_in_valid <= 1'b0;
                        end
                    end
                end
                RD_ISS: begin
                    if (!ctrl_busy) begin
                        state         <= RD_WAIT;
                        ctrl_in_valid <= 1'b0;
                        timer         <= '0;
                    end
                end
                RD_WAIT: begin
                    if (ctrl_out_valid) begin
                        wbs_dat_o <= ctrl_rdata;
                        wbs_ack_o <= 1'b1;
                        state     <= RD_ACK;
                    end else if (timer == TMAX) begin
                        // Placed after the clear so a same-cycle clear loses.
                        wbs_dat_o <= 32'hFFFF_FFFF;
                        wbs_ack_o <= 1'b1;
                        err_o     <= 1'b1;
                        state     <= RD_ACK;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RD_ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Bench for wb_sdram_bridge: WB master tasks, a reactive controller model, and a scoreboard of expected controller commands.
module tb_wb_sdram_bridge;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [22:0] ctrl_addr;
    logic        ctrl_rw;
    logic [31:0] ctrl_wdata;
    logic [3:0]  ctrl_mask;
    logic        ctrl_in_valid;
    logic        ctrl_busy = 1'b0;
    logic [31:0] ctrl_rdata = '0;
    logic        ctrl_out_valid = 1'b0;
    logic [2:0]  wfifo_level;
    logic        err_o;
    logic        err_clr_i = 1'b0;

    wb_sdram_bridge #(
        .ADDR_BITS(23), .WFIFO_DEPTH(DEPTH), .BASE_ADDR(32'h3800_0000), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
        .ctrl_mask(ctrl_mask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
        .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid),
        .wfifo_level(wfifo_level), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [22:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } cmd_t;

    cmd_t        exp_q [$];
    logic [31:0] exp_mem [int];
    logic [31:0] ctrl_mem [int];
    cmd_t        last_cmd;

    int total = 0;
    int bad = 0;
    int rd_delay = 0;
    int rd_cnt = -1;
    logic [31:0] rd_pend = '0;
    int xfer_cnt = 0;
    int ival_cycles = 0;
    int level_peak = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_window(input logic [31:0] adr);
        return (adr >> 25) == (32'h3800_0000 >> 25);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] adr);
        if (!in_window(adr)) return '0;
        if (exp_mem.exists(int'(adr[24:2]))) return exp_mem[int'(adr[24:2])];
        return '0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One WB transaction; the expected controller command is queued at issue time in WB order.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int n);
        cmd_t c;
        if (in_window(adr)) begin
            c.rw   = we;
            c.addr = adr[24:2];
            c.data = we ? dat : 32'h0;
            c.mask = we ? sel : 4'h0;
            exp_q.push_back(c);
            if (we) exp_mem[int'(adr[24:2])] = merge(exp_rd(adr), dat, sel);
        end
        @(posedge clk);
        #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wbs_ack_o && n < 400);
        if (!wbs_ack_o) begin
            total++; bad++;
            $display("FAIL wb_ack_timeout: no ack after %0d cycles, adr=%h", n, adr);
        end
        rdat = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 32'(wbs_ack_o), 0);
        chk({tag, "_dat"}, wbs_dat_o, 0);
        chk({tag, "_in_valid"}, 32'(ctrl_in_valid), 0);
        chk({tag, "_rw"}, 32'(ctrl_rw), 0);
        chk({tag, "_addr"}, 32'(ctrl_addr), 0);
        chk({tag, "_wdata"}, ctrl_wdata, 0);
        chk({tag, "_mask"}, 32'(ctrl_mask), 0);
        chk({tag, "_level"}, 32'(wfifo_level), 0);
        chk({tag, "_err"}, 32'(err_o), 0);
    endtask

    // Compare process: controller-side commands against the scoreboard, plus hold stability.
    initial begin
        cmd_t c;
        cmd_t held;
        bit   prev_hold;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(ctrl_in_valid), 1);
                chk("hold_rw", 32'(ctrl_rw), 32'(held.rw));
                chk("hold_addr", 32'(ctrl_addr), 32'(held.addr));
                chk("hold_mask", 32'(ctrl_mask), 32'(held.mask));
                if (held.rw) chk("hold_wdata", ctrl_wdata, held.data);
            end
            chk("level_bound", 32'(int'(wfifo_level) <= DEPTH), 1);
            if (int'(wfifo_level) > level_peak) level_peak = int'(wfifo_level);
            if (ctrl_in_valid) ival_cycles++;
            prev_hold = ctrl_in_valid && ctrl_busy;
            held.rw = ctrl_rw; held.addr = ctrl_addr; held.data = ctrl_wdata; held.mask = ctrl_mask;
            if (ctrl_in_valid && !ctrl_busy) begin
                xfer_cnt++;
                last_cmd = held;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cmd: rw=%0d addr=%h, expected none", ctrl_rw, ctrl_addr);
                end else begin
                    c = exp_q.pop_front();
                    chk("cmd_rw", 32'(ctrl_rw), 32'(c.rw));
                    chk("cmd_addr", 32'(ctrl_addr), 32'(c.addr));
                    chk("cmd_mask", 32'(ctrl_mask), 32'(c.mask));
                    if (c.rw) chk("cmd_wdata", ctrl_wdata, c.data);
                end
                if (ctrl_rw) begin
                    ctrl_mem[int'(ctrl_addr)] = merge(ctrl_mem.exists(int'(ctrl_addr)) ? ctrl_mem[int'(ctrl_addr)] : 32'h0,
                                                      ctrl_wdata, ctrl_mask);
                end else if (rd_delay >= 0) begin
                    rd_cnt  = rd_delay;
                    rd_pend = ctrl_mem.exists(int'(ctrl_addr)) ? ctrl_mem[int'(ctrl_addr)] : 32'h0;
                end
            end
        end
    end

    // Controller read-return model: out_valid pulses rd_delay cycles after the transfer cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ctrl_out_valid = 1'b0;
            if (rd_cnt == 0) begin
                ctrl_out_valid = 1'b1;
                ctrl_rdata     = rd_pend;
                rd_cnt         = -1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rd5;
        int n;
        int n5;
        int x0;
        int v0;
        int acks;

        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single posted write
        wb_xfer(1'b1, 32'h3800_0010, 32'hA5A5_5A5A, 4'hF, rd, n);
        chk("t1_ack_lat", 32'(n), 1);
        chk("t1_level_one", 32'(wfifo_level), 1);
        idle(6);
        chk("t1_level_zero", 32'(wfifo_level), 0);
        chk("t1_ctrl_addr", 32'(last_cmd.addr), 32'd4);
        chk("t1_ctrl_mask", 32'(last_cmd.mask), 32'hF);
        chk("t1_ctrl_wdata", last_cmd.data, 32'hA5A5_5A5A);

        // Five writes against a busy controller
        level_peak = 0;
        ctrl_busy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1'b1, 32'h3800_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF, rd, n);
            chk("t2_ack_lat", 32'(n), 1);
        end
        chk("t2_level_full", 32'(wfifo_level), 4);
        fork
            wb_xfer(1'b1, 32'h3800_0110, 32'h1000_0004, 4'hF, rd5, n5);
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("t2_stall_no_ack", 32'(wbs_ack_o), 0);
                chk("t2_stall_level", 32'(wfifo_level), 4);
                ctrl_busy = 1'b0;
                @(posedge clk);
                #1;
                chk("t2_full_pop_not_accepted", 32'(wbs_ack_o), 0);
                @(posedge clk);
                #1;
                chk("t2_accept_after_pop", 32'(wbs_ack_o), 1);
            end
        join
        chk("t2_fifth_ack_lat", 32'(n5), 7);
        idle(15);
        chk("t2_level_drained", 32'(wfifo_level), 0);
        chk("t2_level_peak", 32'(level_peak), 4);

        // Read behind posted writes, with byte-merge
        x0 = xfer_cnt;
        rd_delay = 2;
        wb_xfer(1'b1, 32'h3800_0020, 32'h1122_3344, 4'hF, rd, n);
        chk("t3_w1_lat", 32'(n), 1);
        wb_xfer(1'b1, 32'h3800_0020, 32'hAABB_CCDD, 4'h5, rd, n);
        chk("t3_w2_lat", 32'(n), 1);
        wb_xfer(1'b1, 32'h3800_0024, 32'hCAFE_F00D, 4'h3, rd, n);
        chk("t3_w3_lat", 32'(n), 1);
        wb_xfer(1'b0, 32'h3800_0020, 32'h0, 4'h0, rd, n);
        chk("t3_rd_literal", rd, 32'h11BB_33DD);
        chk("t3_rd_model", rd, exp_rd(32'h3800_0020));
        chk("t3_xfer_count", 32'(xfer_cnt - x0), 4);
        idle(10);
        rd_delay = 0;
        wb_xfer(1'b0, 32'h3800_0024, 32'h0, 4'h0, rd, n);
        chk("t3_min_rd_lat", 32'(n), 3);
        chk("t3_rd2_literal", rd, 32'h0000_F00D);
        chk("t3_rd2_model", rd, exp_rd(32'h3800_0024));

        // Window misses
        x0 = xfer_cnt;
        v0 = ival_cycles;
        wb_xfer(1'b0, 32'h3000_0000, 32'h0, 4'h0, rd, n);
        chk("t4_miss_rd_lat", 32'(n), 1);
        chk("t4_miss_rd_dat", rd, 32'h0);
        wb_xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, rd, n);
        chk("t4_miss_wr_lat", 32'(n), 1);
        idle(4);
        chk("t4_miss_level", 32'(wfifo_level), 0);
        chk("t4_no_xfer", 32'(xfer_cnt - x0), 0);
        chk("t4_no_in_valid", 32'(ival_cycles - v0), 0);

        // Read timeout, with a clear held across the timeout cycle
        rd_delay  = -1;
        err_clr_i = 1'b1;
        wb_xfer(1'b0, 32'h3800_0080, 32'h0, 4'h0, rd, n);
        chk("t5_timeout_lat", 32'(n), 32'(TIMEOUT + 3));
        chk("t5_timeout_dat", rd, 32'hFFFF_FFFF);
        chk("t5_err_set_wins", 32'(err_o), 1);
        err_clr_i = 1'b0;
        idle(3);
        chk("t5_err_sticky", 32'(err_o), 1);
        err_clr_i = 1'b1;
        idle(1);
        err_clr_i = 1'b0;
        chk("t5_err_cleared", 32'(err_o), 0);
        rd_pend = 32'h1234_5678;
        rd_cnt  = 0;
        acks    = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (wbs_ack_o) acks++;
        end
        chk("t5_late_valid_ignored", 32'(acks), 0);

        // Reset while waiting on a read with two writes queued behind it
        exp_q.push_back('{rw: 1'b0, addr: 23'h10, data: 32'h0, mask: 4'h0});
        @(posedge clk);
        #1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0040;
        repeat (4) @(posedge clk);
        #1;
        wbs_we_i = 1'b1; wbs_adr_i = 32'h3800_0044; wbs_dat_i = 32'h5555_AAAA; wbs_sel_i = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        chk("t6_level_before_rst", 32'(wfifo_level), 2);
        x0 = xfer_cnt;
        v0 = ival_cycles;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("t6_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (wbs_ack_o) acks++;
        end
        chk("t6_no_ack", 32'(acks), 0);
        chk("t6_level_after", 32'(wfifo_level), 0);
        chk("t6_no_xfer", 32'(xfer_cnt - x0), 0);
        chk("t6_no_in_valid", 32'(ival_cycles - v0), 0);
        chk("exp_q_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
